// File: rtl/sar_magnitude_search.sv
// Successive-approximation search for an unknown WIDTH-bit value held on the
// data_a side of an external magnitude comparator. This block drives the
// probe (data_b) and reads back aeqb/agtb/altb, resolving one bit per edge
// MSB-first and stopping early as soon as the probe equals the target.
//
// state  | meaning
// IDLE   | waiting for start; result/error hold the last search outcome
// SEARCH | probe is on the comparator; each edge judges its flags
module sar_magnitude_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             aeqb,
  input  logic             agtb,
  input  logic             altb,
  output logic [WIDTH-1:0] probe,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH-1);
  localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH-1);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] probe_q, acc_q, result_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q, done_q, error_q;

  logic             onehot;
  logic             last_bit;
  logic             finish;
  logic [IW-1:0]    idx_d;
  logic [WIDTH-1:0] acc_d, probe_d;

  // Judge the current flags: keep the trial bit on agtb, drop it on altb,
  // and build the next trial by setting the next-lower bit.
  always_comb begin
    onehot   = (aeqb ^ agtb ^ altb) & ~(aeqb & agtb & altb);
    last_bit = (idx_q == '0);
    finish   = ~onehot | aeqb | last_bit;
    acc_d    = agtb ? probe_q : acc_q;
    idx_d    = idx_q - 1'b1;
    probe_d  = acc_d | (ONE << idx_d);
  end

  // Search FSM with all outputs registered; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      acc_q    <= '0;
      idx_q    <= IDX_TOP;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            probe_q <= MSB;
            acc_q   <= '0;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (finish) begin
            // Flag-integrity failure takes precedence over any flag value.
            if (!onehot) begin
              result_q <= '0;
              error_q  <= 1'b1;
            end else if (aeqb) begin
              result_q <= probe_q;
            end else begin
              result_q <= acc_d;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            probe_q <= '0;
          end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            probe_q <= probe_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe  = probe_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule

// File: tb/tb_sar_magnitude_search.sv
// Bench for sar_magnitude_search at WIDTH=4. The comparator is modelled
// inline from the target register. Stimulus pushes the expected probe
// sequence and the expected outcome into queues; a monitor checks probes
// every busy cycle and the outcome on every done pulse.
module tb_sar_magnitude_search;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start;
  logic         aeqb, agtb, altb;
  logic [W-1:0] probe, result;
  logic         busy, done, error;

  logic [W-1:0] target;
  logic         force_none;

  int tests = 0;
  int fails = 0;

  exp_t         exp_q[$];
  logic [W-1:0] probe_exp_q[$];

  always #5 clk = ~clk;

  assign aeqb = !force_none && (target == probe);
  assign agtb = !force_none && (target >  probe);
  assign altb = !force_none && (target <  probe);

  sar_magnitude_search #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .aeqb(aeqb), .agtb(agtb), .altb(altb),
    .probe(probe), .result(result), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Trial k keeps the target's bits above k and sets bit k.
  function automatic logic [W-1:0] trial(input int t, input int k);
    int v;
    v = ((t >> (k + 1)) << (k + 1)) | (1 << k);
    return W'(v);
  endfunction

  // A search ends when the trial equals the target, i.e. at the lowest set
  // bit; a zero target runs through every bit.
  function automatic int latency(input int t);
    if (t == 0) return W;
    for (int b = 0; b < W; b++)
      if (((t >> b) & 1) == 1) return W - b;
    return W;
  endfunction

  // mode 0: normal, 1: flags forced low in 2nd cycle, 2: reset in 2nd cycle.
  // Entered and returned at a negedge; returns in the done cycle.
  task automatic search(input int t, input int mode, input bit hold);
    exp_t e;
    int   lat;
    bit   seen;
    target = W'(t);
    start  = 1'b1;
    lat    = (mode == 0) ? latency(t) : 2;
    for (int k = W - 1; k >= W - lat; k--) probe_exp_q.push_back(trial(t, k));
    if (mode == 1) begin
      e.res = '0; e.err = 1'b1; e.lat = 2;
      exp_q.push_back(e);
    end else if (mode == 0) begin
      e.res = W'(t); e.err = 1'b0; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); @(negedge clk);
    if (!hold) start = 1'b0;
    if (mode != 0) begin
      @(posedge clk); @(negedge clk);
      if (mode == 1) force_none = 1'b1;
      else           reset = 1'b1;
      @(posedge clk); @(negedge clk);
      force_none = 1'b0;
      if (mode == 2) begin
        reset = 1'b0;
        chk("abort_probe",  int'(probe),  0);
        chk("abort_result", int'(result), 0);
        chk("abort_busy",   int'(busy),   0);
        chk("abort_done",   int'(done),   0);
        chk("abort_error",  int'(error),  0);
        return;
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      fails++; tests++;
      $display("FAIL done_timeout: got no done expected done for target %0d", t);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: probe sequence while busy, outcome on done.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      if (probe_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL probe_extra: got probe %0d expected no busy cycle", probe);
      end else begin
        chk("probe_seq", int'(probe), int'(probe_exp_q.pop_front()));
      end
    end else if (done) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got done expected none, result %0d", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result",      int'(result), int'(e.res));
        chk("error",       int'(error),  int'(e.err));
        chk("latency",     busy_cnt,     e.lat);
        chk("probe_at_done", int'(probe), 0);
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; target = '0; force_none = 1'b0;
    idle(3);
    chk("rst_probe",  int'(probe),  0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy",   int'(busy),   0);
    chk("rst_done",   int'(done),   0);
    chk("rst_error",  int'(error),  0);
    reset = 1'b0;
    idle(2);

    search(12, 0, 0); idle(2);
    search(5, 0, 0);  idle(1);
    search(0, 0, 0);  idle(1);
    search(15, 0, 0);
    search(10, 0, 0);            // issued in the done cycle of the previous one
    idle(1);
    search(13, 1, 0); idle(1);
    search(3, 0, 0);  idle(2);
    search(9, 2, 0);  idle(2);
    search(9, 0, 1);  idle(2);   // start held high for the whole search

    for (int i = 0; i < 24; i++) begin
      search(int'($urandom_range(0, (1 << W) - 1)), 0, bit'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    chk("exp_q_drained",   exp_q.size(),       0);
    chk("probe_q_drained", probe_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sar_magnitude_search.md
Name: sar_magnitude_search

Overview:
- Sequential controller that finds an unknown WIDTH-bit value by driving a probe operand into a `magnitude_comparator` and reading back its three flags.
- Comparator wiring: data_a = unknown target, data_b = probe, flags return here.
- Performs an MSB-first successive-approximation search with early exit on equality, then reports the recovered value.
- Sits on the operand-driving end of the comparator interface: it produces the operand and consumes aeqb/agtb/altb.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a search; sampled only in IDLE.
- aeqb  input  1  comparator flag, target == probe.
- agtb  input  1  comparator flag, target > probe.
- altb  input  1  comparator flag, target < probe.
- probe  output  WIDTH  registered trial value driven to comparator data_b.
- result  output  WIDTH  recovered target; valid from done pulse until next accepted start.
- busy  output  1  high while searching.
- done  output  1  one-cycle pulse when a search ends.
- error  output  1  set with done when flags were not one-hot; cleared on next accepted start.

Behaviour:
- Reset (sync, active-high, priority over everything):
  - state = IDLE.
  - probe = 0, result = 0, busy = 0, done = 0, error = 0.
  - internal acc = 0, idx = WIDTH-1.
  - Reset mid-search aborts with no done pulse.
- States: IDLE, SEARCH.
- IDLE:
  - Hold result/error.
  - done low except for its single pulse cycle.
  - When start = 1 at an edge: probe <= 1<<(WIDTH-1), acc <= 0, idx <= WIDTH-1, busy <= 1, error <= 0, state <= SEARCH.
  - result is not cleared on start.
- SEARCH: each edge evaluates the flags seen during the preceding cycle against the current probe. The comparator is combinational; no settle cycle is needed.
  - Flags not exactly one-hot (zero or more than one high): result <= 0, error <= 1, go to finish.
  - aeqb: result <= probe, go to finish (early exit).
  - agtb: acc_n = probe (bit idx kept).
  - altb: acc_n = acc (bit idx dropped).
  - If agtb/altb and idx == 0: result <= acc_n, go to finish.
  - Otherwise: acc <= acc_n, idx <= idx-1, probe <= acc_n | (1<<(idx-1)).
- Finish (same edge): state <= IDLE, busy <= 0, done <= 1 for exactly one cycle, probe <= 0.
- start while busy: ignored, no queuing.
- start high during the done cycle: accepted (state already IDLE). The new search begins at that edge; done still drops next cycle.
- Latency: start edge to done edge is 1..WIDTH evaluation edges. Worst case WIDTH, when the target equals 0 or is only resolved at bit 0.
- Arithmetic: all probe/acc values stay within WIDTH bits; no carries.
  - The bit-0 trial for target 2^WIDTH-1 equals all-ones and ends on aeqb.
  - Target 0 never matches; it ends via idx == 0 with altb.
- The block never drives outputs from inputs combinationally; all outputs are registered.

Test Plan (WIDTH=4; bench wires `magnitude_comparator` with data_a = target, data_b = probe):
- target=12, pulse start → probe 8 (agtb), 12 (aeqb); done after 2 edges; result=12, error=0, busy low with done.
- target=5 → probes 8,4,6,5; aeqb on 4th; result=5 after 4 evaluation edges.
- target=0 → probes 8,4,2,1, all altb; done on 4th edge; result=0, error=0, probe returns 0.
- target=15 → probes 8,12,14,15; result=15. Then target=10 → probes 8,12,10; result=10 in 3 edges, with the start issued during the previous done cycle accepted.
- Bench forces flags to 0 (none high) in the 2nd search cycle → done with error=1, result=0. A following normal search (target=3) clears error and returns 3.
- target=9, assert reset during the 2nd search cycle → all outputs 0 next cycle, no done. A start held high throughout a later search does not restart it; result=9 after a clean run.
